// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: captures each completed UART frame once into a FWFT FIFO,
// delivers it over valid/ready, and flags overrun, idle line and stuck receiver.
//   clk, rst_n            : clock, async active-low reset
//   rx_received/receiving : receiver frame-complete and busy levels
//   rx_data               : receiver byte, stable while rx_received is high
//   m_data/m_valid/m_ready: downstream byte handshake (FIFO head)
//   level                 : FIFO occupancy 0..DEPTH
//   overrun, stall_err    : sticky error flags, cleared by clear
//   idle                  : one-cycle pulse after a quiet line following a capture
module uart_rx_frame_ctrl #(
    parameter int DEPTH        = 4,
    parameter int IDLE_TIMEOUT = 160,
    parameter int STALL_LIMIT  = 320
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_received,
    input  logic                   rx_receiving,
    input  logic [7:0]             rx_data,
    output logic [7:0]             m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overrun,
    output logic                   stall_err,
    output logic                   idle,
    input  logic                   clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic {
        S_DISARMED,
        S_ARMED
    } idle_state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_prev_rcv;
    logic          r_overrun;
    logic          r_stall_err;
    logic [SW-1:0] r_stall_cnt;
    idle_state_t   r_state;
    logic [IW-1:0] r_idle_cnt;
    logic          r_idle;

    logic          w_capture;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_ovr_set;
    logic          w_stall_set;
    idle_state_t   w_state_nxt;
    logic [IW-1:0] w_idle_cnt_nxt;
    logic          w_idle_nxt;

    // Rising edge of rx_received; r_prev_rcv resets high so a level
    // already high at reset release is not taken as a new frame.
    assign w_capture = !r_prev_rcv && rx_received;
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_pop     = m_valid && m_ready;
    // When full, a push is only allowed if the head leaves in the same cycle.
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_ovr_set = w_capture && w_full && !w_pop;

    // Set while the saturated count is (or becomes) the limit, so a stuck
    // receiver keeps re-asserting the flag against clear.
    assign w_stall_set = rx_receiving &&
                         (r_stall_cnt >= SW'(STALL_LIMIT - 1));

    assign m_valid   = (r_level != '0);
    assign m_data    = m_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign level     = r_level;
    assign overrun   = r_overrun;
    assign stall_err = r_stall_err;
    assign idle      = r_idle;

    always_comb begin
        w_state_nxt    = r_state;
        w_idle_cnt_nxt = r_idle_cnt;
        w_idle_nxt     = 1'b0;
        if (w_capture) begin
            // A capture always re-arms, even on the terminal count.
            w_state_nxt    = S_ARMED;
            w_idle_cnt_nxt = '0;
        end else if (r_state == S_ARMED) begin
            if (rx_receiving) begin
                w_idle_cnt_nxt = '0;
            end else if (r_idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
                w_idle_nxt     = 1'b1;
                w_state_nxt    = S_DISARMED;
                w_idle_cnt_nxt = '0;
            end else begin
                w_idle_cnt_nxt = r_idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_rcv  <= 1'b1;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overrun   <= 1'b0;
            r_stall_err <= 1'b0;
            r_stall_cnt <= '0;
            r_state     <= S_DISARMED;
            r_idle_cnt  <= '0;
            r_idle      <= 1'b0;
        end else begin
            r_prev_rcv <= rx_received;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
            r_overrun   <= (r_overrun && !clear) || w_ovr_set;
            r_stall_err <= (r_stall_err && !clear) || w_stall_set;
            if (!rx_receiving) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != SW'(STALL_LIMIT)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_idle     <= w_idle_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and randomized frames against a
// queue/timestamp reference model of the frame controller.
module tb_uart_rx_frame_ctrl;

    localparam int DEPTH = 4;
    localparam int IT    = 160;
    localparam int SL    = 320;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_received;
    logic       rx_receiving;
    logic [7:0] rx_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [2:0] level;
    logic       overrun;
    logic       stall_err;
    logic       idle;
    logic       clear;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    bit md_prev;
    bit md_ovr;
    bit md_stall;
    bit md_idle;
    bit md_armed;
    int md_run;
    int md_qstart;
    int edge_n;

    uart_rx_frame_ctrl #(
        .DEPTH(DEPTH),
        .IDLE_TIMEOUT(IT),
        .STALL_LIMIT(SL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_received(rx_received),
        .rx_receiving(rx_receiving),
        .rx_data(rx_data),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .level(level),
        .overrun(overrun),
        .stall_err(stall_err),
        .idle(idle),
        .clear(clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        md_prev   = 1'b1;
        md_ovr    = 1'b0;
        md_stall  = 1'b0;
        md_idle   = 1'b0;
        md_armed  = 1'b0;
        md_run    = 0;
        md_qstart = 0;
    endtask

    task automatic chk_all();
        chk("m_valid", {31'd0, m_valid}, {31'd0, q.size() != 0});
        chk("level", {29'd0, level}, q.size());
        if (q.size() != 0) chk("m_data", {24'd0, m_data}, {24'd0, q[0]});
        chk("overrun", {31'd0, overrun}, {31'd0, md_ovr});
        chk("stall_err", {31'd0, stall_err}, {31'd0, md_stall});
        chk("idle", {31'd0, idle}, {31'd0, md_idle});
    endtask

    // One clock: update the model from the current inputs, clock, check.
    task automatic step();
        bit cap, full, pop, push, set_o, set_s, pulse;
        edge_n++;
        cap   = !md_prev && (rx_received === 1'b1);
        full  = (q.size() == DEPTH);
        pop   = (q.size() != 0) && (m_ready === 1'b1);
        push  = cap && (!full || pop);
        set_o = cap && full && !pop;
        if (rx_receiving === 1'b1) md_run++;
        else md_run = 0;
        set_s = (md_run >= SL);
        // idle: armed timer fires IT edges after the start of the quiet run
        pulse = 1'b0;
        if (cap) begin
            md_armed  = 1'b1;
            md_qstart = edge_n;
        end else if (md_armed && rx_receiving === 1'b1) begin
            md_qstart = edge_n;
        end else if (md_armed && (edge_n - md_qstart == IT)) begin
            pulse    = 1'b1;
            md_armed = 1'b0;
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back(rx_data);
        md_ovr   = (md_ovr && !clear) || set_o;
        md_stall = (md_stall && !clear) || set_s;
        md_idle  = pulse;
        md_prev  = rx_received;
        @(posedge clk);
        #1;
        chk_all();
    endtask

    task automatic send_frame(input logic [7:0] b, input int busy,
                              input bit rdy);
        rx_received  = 1'b0;
        rx_receiving = 1'b1;
        rx_data      = 8'($urandom);
        repeat (busy) step();
        rx_receiving = 1'b0;
        rx_received  = 1'b1;
        rx_data      = b;
        m_ready      = rdy;
        step();
    endtask

    initial begin
        int cnt;
        int at;
        rst_n        = 1'b0;
        rx_received  = 1'b1;
        rx_receiving = 1'b0;
        rx_data      = 8'h00;
        m_ready      = 1'b0;
        clear        = 1'b0;
        edge_n       = 0;
        model_reset();
        #12;
        chk("rst_m_data", {24'd0, m_data}, 32'h0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'h0);
        chk("rst_level", {29'd0, level}, 32'h0);
        chk("rst_overrun", {31'd0, overrun}, 32'h0);
        chk("rst_stall", {31'd0, stall_err}, 32'h0);
        chk("rst_idle", {31'd0, idle}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // single byte, received held high for 500 cycles
        send_frame(8'hA5, 10, 1'b0);
        repeat (500) step();
        chk("single_level", {29'd0, level}, 32'd1);
        chk("single_data", {24'd0, m_data}, 32'hA5);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;

        // overrun
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 3, 1'b0);
        chk("ovr_level", {29'd0, level}, 32'd4);
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovr_pop", {24'd0, m_data}, i);
            step();
        end
        m_ready = 1'b0;
        chk("ovr_empty", {31'd0, m_valid}, 32'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("ovr_clear", {31'd0, overrun}, 32'd0);

        // full with simultaneous push and pop
        for (int i = 0; i < 4; i++) send_frame(8'(8'h10 + i), 3, 1'b0);
        send_frame(8'h77, 3, 1'b1);
        m_ready = 1'b0;
        chk("full_level", {29'd0, level}, 32'd4);
        chk("full_ovr", {31'd0, overrun}, 32'd0);
        m_ready = 1'b1;
        repeat (3) step();
        chk("full_last", {24'd0, m_data}, 32'h77);
        step();
        m_ready = 1'b0;

        // idle pulse 160 cycles after a lone capture
        repeat (200) step();
        send_frame(8'h42, 5, 1'b0);
        cnt = 0;
        at  = -1;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (idle === 1'b1) begin
                cnt++;
                at = k;
            end
        end
        chk("idle_count", cnt, 32'd1);
        chk("idle_at", at, 32'd160);

        // second frame starting at cycle 100 defers the pulse
        send_frame(8'h43, 5, 1'b0);
        repeat (99) step();
        send_frame(8'h44, 8, 1'b0);
        cnt = 0;
        at  = -1;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (idle === 1'b1) begin
                cnt++;
                at = k;
            end
        end
        chk("idle2_count", cnt, 32'd1);
        chk("idle2_at", at, 32'd160);
        m_ready = 1'b1;
        repeat (4) step();
        m_ready = 1'b0;

        // stall detector
        rx_receiving = 1'b1;
        repeat (SL - 1) step();
        chk("stall_pre", {31'd0, stall_err}, 32'd0);
        step();
        chk("stall_set", {31'd0, stall_err}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("stall_hold", {31'd0, stall_err}, 32'd1);
        rx_receiving = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("stall_clr", {31'd0, stall_err}, 32'd0);

        // reset mid-stream
        for (int i = 0; i < 3; i++) send_frame(8'(8'hC0 + i), 4, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_level", {29'd0, level}, 32'd0);
        rst_n = 1'b1;
        repeat (5) step();
        chk("rst_nocap", {29'd0, level}, 32'd0);
        send_frame(8'h5A, 4, 1'b0);
        chk("rst_recap_lvl", {29'd0, level}, 32'd1);
        chk("rst_recap_dat", {24'd0, m_data}, 32'h5A);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            m_ready = 1'($urandom_range(0, 1));
            send_frame(8'($urandom), $urandom_range(1, 12),
                       1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 6)) begin
                m_ready = 1'($urandom_range(0, 1));
                clear   = ($urandom_range(0, 15) == 0);
                step();
            end
            clear = 1'b0;
            if (n % 50 == 0) begin
                m_ready = 1'b1;
                repeat (170) step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Receive-side controller for the 16x-oversampled UART receiver. It watches the receiver's `received`/`receiving` status and `data_out` byte, and captures each completed frame exactly once into a small first-word-fall-through FIFO. It delivers bytes downstream over a valid/ready handshake and reports overrun, line-idle and stuck-receiver conditions. It sits between the receiver and any byte consumer, such as a command parser or display logic.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `IDLE_TIMEOUT`, 160: cycles of quiet line after the last captured byte before `idle` pulses (10 bit times at 16x).
- `STALL_LIMIT`, 320: consecutive cycles of `rx_receiving` high that flag a stuck receiver.

- `clk` in 1: sampling clock, the same clock the receiver uses.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_received` in 1: receiver frame-complete level. Low while a frame is in progress, high once the stop bit has been sampled.
- `rx_receiving` in 1: receiver busy level.
- `rx_data` in 8: receiver byte. Stable whenever `rx_received` is high.
- `m_data` out 8: FIFO head byte.
- `m_valid` out 1: FIFO non-empty.
- `m_ready` in 1: consumer accepts the head byte.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `overrun` out 1: sticky; a byte was dropped because the FIFO was full.
- `stall_err` out 1: sticky; `rx_receiving` stayed high for ≥STALL_LIMIT cycles.
- `idle` out 1: one-cycle pulse when the line has been quiet for IDLE_TIMEOUT cycles after a capture.
- `clear` in 1: synchronous clear of `overrun` and `stall_err`.

## Operation
- **Reset values.** All outputs reset to 0: `m_data`=0x00, `m_valid`=0, `level`=0, `overrun`=0, `stall_err`=0, `idle`=0. Pointers and timers reset to 0. The edge register `prev_rcv` resets to 1, so a receiver whose `received` is X or 1 at power-up does not produce a spurious capture.
- **Capture.** Capture occurs when `prev_rcv`=0 and `rx_received`=1, i.e. on a rising edge of `rx_received`. `rx_data` is written to the FIFO tail in that same cycle. `prev_rcv <= rx_received` every cycle. Exactly one capture per frame.
- **FIFO.**
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `level` is tracked explicitly: +1 on push only, −1 on pop only, unchanged when both occur.
  - Pop happens when `m_valid` && `m_ready`.
  - `m_data` is the entry at the read pointer (first-word-fall-through).
- **Simultaneous push and pop while full.** Both are performed; no overrun.
- **Full, push, no pop.** The byte is discarded, pointers are unchanged, and `overrun` is set.
- **Pop while empty.** Impossible by construction; `m_ready` is ignored when `m_valid`=0.
- **Idle timer.**
  - States: DISARMED and ARMED.
  - Any capture moves to ARMED with the counter at 0.
  - In ARMED, `rx_receiving`=1 resets the counter to 0; otherwise the counter increments.
  - When the counter reaches IDLE_TIMEOUT−1, `idle` pulses on the next cycle and the state returns to DISARMED.
  - A capture in the same cycle as the terminal count re-arms the timer and suppresses the pulse.
- **Stall detector.**
  - Counts consecutive cycles with `rx_receiving`=1, saturating at STALL_LIMIT.
  - Clears to 0 whenever `rx_receiving`=0.
  - `stall_err` is set on the cycle the count reaches STALL_LIMIT.
- **Sticky flags.**
  - `clear` zeroes `overrun` and `stall_err`.
  - If a set condition and `clear` occur in the same cycle, the flag ends at 1.
- **Reset mid-operation.** Asserting `rst_n` low forces the reset values immediately. Any queued bytes are lost. A frame already in progress at the receiver is still captured after reset release, provided `rx_received` rises after `prev_rcv` has seen it low.

## Timing
- **Capture latency.** `rx_received` is first high at edge N; with the FIFO empty, `m_valid`=1 and `m_data`=byte are visible after edge N+1. Latency is 1 cycle.
- **Pop.**
  - `m_ready`=1 at edge K with `m_valid`=1: the next entry, or `m_valid`=0, is visible after edge K+1.
  - Back-to-back pops are sustained at one per cycle.
- **Flag latency.** `level`, `overrun` and `stall_err` update in the same register stage as the FIFO (1 cycle after the cause).
- **`idle` width.** Exactly one `clk` cycle.

## Test plan
- **Single byte.** Drive a frame of 0xA5 (`rx_receiving` pulse, then `rx_received` 0→1), `m_ready`=0 → `m_valid`=1, `m_data`=0xA5, `level`=1, exactly one entry even though `rx_received` stays high for 500 cycles.
- **Overrun.** With DEPTH=4 and `m_ready`=0, send 0x01..0x05 → `level`=4, `overrun`=1. Pop four bytes → 0x01, 0x02, 0x03, 0x04; 0x05 is absent. Pulse `clear` → `overrun`=0.
- **Full with simultaneous pop.** With the FIFO full, a capture of 0x77 coincides with a pop → `level` stays 4, `overrun`=0, and 0x77 emerges last.
- **Idle.** Send one byte, then keep the line quiet → `idle` is high for exactly 1 cycle, 160 cycles after the capture. A second frame starting at cycle 100 suppresses the pulse until 160 quiet cycles after its capture.
- **Stall.** Hold `rx_receiving`=1 for 320 cycles → `stall_err`=1 at cycle 320. Assert `clear` and a new stall condition in the same cycle → `stall_err` stays 1.
- **Reset mid-stream.** Fill 3 bytes, pull `rst_n` low asynchronously mid-cycle → `m_valid`=0 and `level`=0 immediately. After release with `rx_received` already 1, there is no capture; the next full frame is captured normally.
